pipe_deser: RTL

Serial-to-parallel front end that produces the WIDTH-bit registered words consumed by the retiming pipeline blocks. It is the inverse direction of the word-to-bit reduction stage.
- Collects a 1-bit stream, LSB first, with per-bit valid and a start-of-frame marker.
- Presents completed words on a valid/ready output port.
- Flags framing and overrun errors.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_deser.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipe_* front-end blocks.
//
// Contents:
//   PIPE_W      default word width of the pipeline
//   POS_MAX_W   widest word pos_reduce() can evaluate
//   pos_reduce  AND over k of (word[2k] | word[2k+1]) for the low `width` bits
package pipe_pkg;

    localparam int PIPE_W    = 8;
    localparam int POS_MAX_W = 64;

    // Product-of-sums over adjacent bit pairs. Bits at or above `width` are
    // ignored so a narrower word can be passed zero-extended.
    function automatic logic pos_reduce(input logic [POS_MAX_W-1:0] word,
                                        input int                   width);
        logic r;
        r = 1'b1;
        for (int k = 0; k < POS_MAX_W / 2; k++) begin
            if (k < width / 2) begin
                r = r & (word[2*k] | word[2*k+1]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_deser.sv
// pipe_deser -- serial-to-parallel front end (LSB first).
//
// Collects a 1-bit stream with per-bit valid and a start-of-frame marker and
// presents each completed WIDTH-bit word on a valid/ready port. Flags framing
// errors (SOF arriving mid-word) and overruns (word completes while the
// previous one is still unconsumed). Both flags are sticky until i_clr_err;
// a set event in the same cycle as i_clr_err wins.
//
// Optional feature (macro PIPE_DESER_POS_EN): adds o_pos, the pair-OR/AND
// reduction of the output word, loaded alongside o_data.
//
// Ports:
//   i_clk       clock, all logic on posedge
//   i_rst       synchronous reset, active-high
//   i_bit       serial data bit
//   i_valid     i_bit valid this cycle
//   i_sof       with i_valid: this bit is bit 0 of a new word
//   o_data      assembled word, bit 0 = first received bit
//   o_valid     o_data holds an unconsumed word
//   i_ready     downstream accepts o_data when o_valid && i_ready
//   o_ovf       sticky overrun flag
//   o_sync_err  sticky framing-error flag
//   i_clr_err   clears both sticky flags
//   o_pos       (PIPE_DESER_POS_EN only) pos_reduce of o_data
module pipe_deser
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit,
    input  logic             i_valid,
    input  logic             i_sof,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_ovf,
    output logic             o_sync_err,
`ifdef PIPE_DESER_POS_EN
    output logic             o_pos,
`endif
    input  logic             i_clr_err
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    // Only WIDTH-1 bits are stored: the final bit goes straight to o_data.
    logic [WIDTH-2:0] shreg;

    logic             last_bit;
    logic             complete;
    logic             can_load;
    logic             sync_set;
    logic             ovf_set;
    logic [WIDTH-1:0] word;

    always_comb begin
        last_bit = (cnt == CW'(WIDTH - 1));
        // SOF always restarts at bit 0, so it can never complete a word.
        complete = i_valid && !i_sof && last_bit;
        can_load = !o_valid || i_ready;
        sync_set = i_valid && i_sof && (cnt != '0);
        ovf_set  = complete && !can_load;
        word     = {i_bit, shreg};
    end

`ifdef PIPE_DESER_POS_EN
    logic [POS_MAX_W-1:0] word_wide;
    logic                 word_pos;

    always_comb begin
        word_wide              = '0;
        word_wide[WIDTH-1:0]   = word;
        word_pos               = pos_reduce(word_wide, WIDTH);
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            shreg      <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_ovf      <= 1'b0;
            o_sync_err <= 1'b0;
`ifdef PIPE_DESER_POS_EN
            o_pos      <= 1'b0;
`endif
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (i_valid) begin
                if (i_sof) begin
                    shreg    <= '0;
                    shreg[0] <= i_bit;
                    cnt      <= CW'(1);
                end else if (last_bit) begin
                    cnt <= '0;
                    if (can_load) begin
                        o_data  <= word;
                        o_valid <= 1'b1;
`ifdef PIPE_DESER_POS_EN
                        o_pos   <= word_pos;
`endif
                    end
                end else begin
                    shreg[cnt] <= i_bit;
                    cnt        <= cnt + CW'(1);
                end
            end

            o_ovf      <= ovf_set  | (o_ovf      & ~i_clr_err);
            o_sync_err <= sync_set | (o_sync_err & ~i_clr_err);
        end
    end

endmodule
